// File: rtl/phy_port_sel_if.sv
// Status and selection bundle between the per-PHY pollers, the port selector
// and the MAC-side consumers.
interface phy_port_sel_if #(
    parameter int PORT_NUM = 2,
    parameter int PW       = (PORT_NUM < 2) ? 1 : $clog2(PORT_NUM)
);
    logic [PORT_NUM-1:0]   port_up;
    logic [2*PORT_NUM-1:0] port_speed;
    logic [PORT_NUM-1:0]   port_duplex;
    logic                  force_en;
    logic [PW-1:0]         force_port;
    logic [PW-1:0]         active_port;
    logic                  link_up;
    logic [1:0]            speed;
    logic                  full_duplex;
    logic                  link_change;
    logic [15:0]           switch_count;

    modport master (
        output port_up, port_speed, port_duplex, force_en, force_port,
        input  active_port, link_up, speed, full_duplex, link_change, switch_count
    );

    modport slave (
        input  port_up, port_speed, port_duplex, force_en, force_port,
        output active_port, link_up, speed, full_duplex, link_change, switch_count
    );
endinterface

// File: rtl/phy_port_sel.sv
// N-port PHY redundancy selector: debounces per-port link status, picks one
// active port (revertive, non-revertive or forced) and presents its link view.
module phy_port_sel #(
    parameter int PORT_NUM    = 2,
    parameter int PW          = (PORT_NUM < 2) ? 1 : $clog2(PORT_NUM),
    parameter int UP_DEBOUNCE = 1000,
    parameter int HOLD_CYCLES = 30000,
    parameter int REVERTIVE   = 0
) (
    input logic         clk,
    input logic         rst_n,
    phy_port_sel_if.slave bus
);

    localparam int DW = $clog2(UP_DEBOUNCE + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(UP_DEBOUNCE);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_NOLINK,
        S_ACTIVE,
        S_HOLD
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   active_port, port_nx;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic            pulse_nx;
    logic            link_change;
    logic [15:0]     switch_count;
    logic [1:0]      speed;
    logic            full_duplex;

    logic [DW-1:0]       deb_cnt [PORT_NUM];
    logic [PORT_NUM-1:0] qual;

    // Rise is debounced, loss of link drops the qualifier on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the debounce counters are ordinary flops, not a RAM, so they
            // take the async reset like every other piece of state.
            for (int i = 0; i < PORT_NUM; i++) deb_cnt[i] <= '0;
            qual <= '0;
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (!bus.port_up[i]) begin
                    deb_cnt[i] <= '0;
                    qual[i]    <= 1'b0;
                end else if (deb_cnt[i] != DEB_MAX) begin
                    // NOTE: state updates use <= so every flop samples pre-edge values.
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    if (deb_cnt[i] == DEB_MAX - DW'(1)) qual[i] <= 1'b1;
                end
            end
        end
    end

    logic          cand_valid, alt_valid, fcand_valid, act_qual;
    logic [PW-1:0] cand, alt;
    logic [1:0]    sel_speed;
    logic          sel_duplex;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        cand_valid  = 1'b0;
        cand        = '0;
        alt_valid   = 1'b0;
        alt         = '0;
        fcand_valid = 1'b0;
        act_qual    = 1'b0;
        sel_speed   = 2'b00;
        sel_duplex  = 1'b0;
        // Scan downwards so the lowest qualified index is the one left standing.
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            if (qual[i]) begin
                cand_valid = 1'b1;
                cand       = PW'(i);
                if (active_port != PW'(i)) begin
                    alt_valid = 1'b1;
                    alt       = PW'(i);
                end
            end
            if (bus.force_port == PW'(i) && qual[i]) fcand_valid = 1'b1;
            if (active_port == PW'(i)) begin
                act_qual   = qual[i];
                sel_speed  = bus.port_speed[2*i +: 2];
                sel_duplex = bus.port_duplex[i];
            end
        end
    end

    always_comb begin
        state_nx = state;
        port_nx  = active_port;
        hold_nx  = hold_cnt;
        pulse_nx = 1'b0;
        unique case (state)
            S_NOLINK: begin
                if (bus.force_en) begin
                    if (fcand_valid) begin
                        port_nx  = bus.force_port;
                        state_nx = S_HOLD;
                        hold_nx  = HOLD_LOAD;
                        pulse_nx = 1'b1;
                    end
                end else if (cand_valid) begin
                    port_nx  = cand;
                    state_nx = S_HOLD;
                    hold_nx  = HOLD_LOAD;
                    pulse_nx = 1'b1;
                end
            end
            default: begin
                if (bus.force_en && !fcand_valid) begin
                    state_nx = S_NOLINK;
                    pulse_nx = 1'b1;
                end else if (bus.force_en && bus.force_port != active_port) begin
                    port_nx  = bus.force_port;
                    state_nx = S_HOLD;
                    hold_nx  = HOLD_LOAD;
                    pulse_nx = 1'b1;
                end else if (!act_qual) begin
                    pulse_nx = 1'b1;
                    if (alt_valid) begin
                        port_nx  = alt;
                        state_nx = S_HOLD;
                        hold_nx  = HOLD_LOAD;
                    end else begin
                        state_nx = S_NOLINK;
                    end
                end else if (state == S_ACTIVE && REVERTIVE != 0 && !bus.force_en &&
                             cand_valid && cand < active_port) begin
                    // A held force pins the port, so reverting only happens unforced.
                    port_nx  = cand;
                    state_nx = S_HOLD;
                    hold_nx  = HOLD_LOAD;
                    pulse_nx = 1'b1;
                end else if (state == S_HOLD) begin
                    if (hold_cnt > HW'(1)) begin
                        hold_nx = hold_cnt - HW'(1);
                    end else begin
                        hold_nx  = '0;
                        state_nx = S_ACTIVE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_NOLINK;
            active_port  <= '0;
            hold_cnt     <= '0;
            link_change  <= 1'b0;
            switch_count <= '0;
            speed        <= 2'b00;
            full_duplex  <= 1'b0;
        end else begin
            state       <= state_nx;
            active_port <= port_nx;
            hold_cnt    <= hold_nx;
            link_change <= pulse_nx;
            if (pulse_nx && switch_count != 16'hFFFF) switch_count <= switch_count + 16'd1;
            // Speed/duplex track the port already selected, hence one cycle behind a switch.
            if (state != S_NOLINK) begin
                speed       <= sel_speed;
                full_duplex <= sel_duplex;
            end
        end
    end

    assign bus.active_port  = active_port;
    assign bus.link_up      = (state != S_NOLINK);
    assign bus.speed        = speed;
    assign bus.full_duplex  = full_duplex;
    assign bus.link_change  = link_change;
    assign bus.switch_count = switch_count;

endmodule

// File: tb/tb_phy_port_sel.sv
// Self-checking bench for phy_port_sel: a non-revertive and a revertive instance
// share the same stimulus; link_change pulses are scored against expected events.
module tb_phy_port_sel;

    localparam int PN = 3;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   sb_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phy_port_sel_if #(.PORT_NUM(PN)) bus_nr ();
    phy_port_sel_if #(.PORT_NUM(PN)) bus_rv ();

    assign bus_rv.port_up     = bus_nr.port_up;
    assign bus_rv.port_speed  = bus_nr.port_speed;
    assign bus_rv.port_duplex = bus_nr.port_duplex;
    assign bus_rv.force_en    = bus_nr.force_en;
    assign bus_rv.force_port  = bus_nr.force_port;

    phy_port_sel #(.PORT_NUM(PN), .UP_DEBOUNCE(4), .HOLD_CYCLES(8), .REVERTIVE(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .bus(bus_nr));
    phy_port_sel #(.PORT_NUM(PN), .UP_DEBOUNCE(4), .HOLD_CYCLES(8), .REVERTIVE(1)) dut_rv (
        .clk(clk), .rst_n(rst_n), .bus(bus_rv));

    typedef struct {
        logic [PW-1:0] port;
        logic          up;
        int            lo;
        int            hi;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Scoreboard: every link_change pulse of the non-revertive instance must
    // match the oldest expected event, including the cycle window it falls in.
    always @(negedge clk) begin
        if (sb_en && rst_n && bus_nr.link_change) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: active_port=%0d link_up=%0b cycle=%0d, required no pulse",
                         bus_nr.active_port, bus_nr.link_up, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus_nr.link_up !== mon_e.up || (mon_e.up && bus_nr.active_port !== mon_e.port) ||
                    cyc < mon_e.lo || cyc > mon_e.hi) begin
                    errors++;
                    $display("FAIL pulse: got port=%0d up=%0b cycle=%0d, required port=%0d up=%0b cycle %0d..%0d",
                             bus_nr.active_port, bus_nr.link_up, cyc, mon_e.port, mon_e.up, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    task automatic push(input logic [PW-1:0] port, input logic up, input int lo, input int hi);
        exp_t e;
        e.port = port; e.up = up; e.lo = lo; e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected pulses never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        bus_nr.port_up     = '0;
        bus_nr.port_speed  = 6'b00_10_01;
        bus_nr.port_duplex = 3'b010;
        bus_nr.force_en    = 1'b0;
        bus_nr.force_port  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb_en = 1'b1;
    endtask

    task automatic test_reset();
        sb_en = 1'b0;
        rst_n = 1'b0;
        bus_nr.port_up = 3'b111;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_nr.active_port !== 2'd0 || bus_nr.link_up !== 1'b0 || bus_nr.speed !== 2'b00 ||
            bus_nr.full_duplex !== 1'b0 || bus_nr.link_change !== 1'b0 || bus_nr.switch_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: port=%0d up=%0b speed=%0b dup=%0b chg=%0b cnt=%0d, required all zero",
                     bus_nr.active_port, bus_nr.link_up, bus_nr.speed, bus_nr.full_duplex,
                     bus_nr.link_change, bus_nr.switch_count);
        end
    endtask

    task automatic test_single_port();
        int c, g;
        do_reset();
        c = cyc;
        bus_nr.port_up = 3'b010;
        push(2'd1, 1'b1, c + 5, c + 5);
        at_cyc(c + 5);
        checks++;
        if (bus_nr.link_up !== 1'b1 || bus_nr.active_port !== 2'd1 || bus_nr.speed !== 2'b00) begin
            errors++;
            $display("FAIL single_select: up=%0b port=%0d speed=%0b, required up=1 port=1 speed=00",
                     bus_nr.link_up, bus_nr.active_port, bus_nr.speed);
        end
        at_cyc(c + 6);
        checks++;
        if (bus_nr.speed !== 2'b10 || bus_nr.full_duplex !== 1'b1 || bus_nr.switch_count !== 16'd1) begin
            errors++;
            $display("FAIL single_follow: speed=%0b dup=%0b cnt=%0d, required speed=10 dup=1 cnt=1",
                     bus_nr.speed, bus_nr.full_duplex, bus_nr.switch_count);
        end
        at_cyc(c + 20);
        g = cyc;
        bus_nr.port_up[2] = 1'b1;
        at_cyc(g + 3);
        bus_nr.port_up[2] = 1'b0;
        g = cyc;
        bus_nr.port_up[0] = 1'b1;
        at_cyc(g + 3);
        bus_nr.port_up[0] = 1'b0;
        at_cyc(g + 15);
        checks++;
        if (bus_nr.active_port !== 2'd1 || bus_rv.active_port !== 2'd1 || bus_nr.switch_count !== 16'd1) begin
            errors++;
            $display("FAIL glitch: nr_port=%0d rv_port=%0d cnt=%0d, required 1 1 1",
                     bus_nr.active_port, bus_rv.active_port, bus_nr.switch_count);
        end
        wait_drain("single");
    endtask

    task automatic test_failover();
        int c, n, m;
        do_reset();
        c = cyc;
        bus_nr.port_up = 3'b011;
        push(2'd0, 1'b1, c + 5, c + 5);
        at_cyc(c + 15);
        n = cyc;
        bus_nr.port_up[0] = 1'b0;
        push(2'd1, 1'b1, n + 2, n + 2);
        at_cyc(n + 5);
        m = cyc;
        bus_nr.port_up[1] = 1'b0;
        push(2'd1, 1'b0, m + 2, m + 2);
        at_cyc(m + 1);
        checks++;
        if (bus_nr.link_up !== 1'b1) begin
            errors++;
            $display("FAIL failover_early: up=%0b at N+1, required 1", bus_nr.link_up);
        end
        at_cyc(m + 3);
        checks++;
        if (bus_nr.link_up !== 1'b0 || bus_nr.switch_count !== 16'd3) begin
            errors++;
            $display("FAIL failover_nolink: up=%0b cnt=%0d, required up=0 cnt=3",
                     bus_nr.link_up, bus_nr.switch_count);
        end
        wait_drain("failover");
    endtask

    task automatic test_simultaneous();
        int c, n;
        do_reset();
        c = cyc;
        bus_nr.port_up = 3'b110;
        push(2'd1, 1'b1, c + 5, c + 5);
        at_cyc(c + 15);
        n = cyc;
        bus_nr.port_up[0] = 1'b1;
        at_cyc(n + 3);
        bus_nr.port_up[1] = 1'b0;
        push(2'd0, 1'b1, n + 5, n + 5);
        at_cyc(n + 5);
        checks++;
        if (bus_nr.active_port !== 2'd0 || bus_nr.link_up !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous: port=%0d up=%0b, required port=0 up=1",
                     bus_nr.active_port, bus_nr.link_up);
        end
        wait_drain("simultaneous");
    endtask

    task automatic test_revert();
        int c, n, s, at;
        bit found;
        do_reset();
        c = cyc;
        bus_nr.port_up = 3'b101;
        push(2'd0, 1'b1, c + 5, c + 5);
        at_cyc(c + 20);
        n = cyc;
        s = n + 2;
        bus_nr.port_up[0] = 1'b0;
        push(2'd2, 1'b1, s, s);
        at_cyc(n + 1);
        bus_nr.port_up[0] = 1'b1;
        at_cyc(s + 7);
        checks++;
        if (bus_rv.active_port !== 2'd2 || bus_rv.link_up !== 1'b1) begin
            errors++;
            $display("FAIL revert_hold: rv_port=%0d up=%0b during hold, required port=2 up=1",
                     bus_rv.active_port, bus_rv.link_up);
        end
        found = 1'b0;
        at = 0;
        while (!found && cyc < s + 12) begin
            @(negedge clk);
            if (bus_rv.link_change) begin
                found = 1'b1;
                at = cyc;
            end
        end
        checks++;
        if (!found || bus_rv.active_port !== 2'd0 || at < s + 8 || at > s + 10) begin
            errors++;
            $display("FAIL revert_switch: seen=%0b port=%0d cycle=%0d, required port=0 cycle %0d..%0d",
                     found, bus_rv.active_port, at, s + 8, s + 10);
        end
        at_cyc(s + 40);
        checks++;
        if (bus_nr.active_port !== 2'd2 || bus_nr.link_up !== 1'b1) begin
            errors++;
            $display("FAIL nonrevert_stay: port=%0d up=%0b, required port=2 up=1",
                     bus_nr.active_port, bus_nr.link_up);
        end
        wait_drain("revert");
    endtask

    task automatic test_force();
        int c, f, k, r;
        do_reset();
        c = cyc;
        bus_nr.port_up = 3'b101;
        push(2'd0, 1'b1, c + 5, c + 5);
        at_cyc(c + 6);
        f = cyc;
        bus_nr.force_en   = 1'b1;
        bus_nr.force_port = 2'd2;
        push(2'd2, 1'b1, f + 1, f + 1);
        at_cyc(f + 1);
        checks++;
        if (bus_nr.active_port !== 2'd2 || bus_nr.link_up !== 1'b1) begin
            errors++;
            $display("FAIL force_switch: port=%0d up=%0b, required port=2 up=1",
                     bus_nr.active_port, bus_nr.link_up);
        end
        at_cyc(f + 4);
        k = cyc;
        bus_nr.force_port = 2'd3;
        push(2'd2, 1'b0, k + 1, k + 1);
        at_cyc(k + 1);
        checks++;
        if (bus_nr.link_up !== 1'b0) begin
            errors++;
            $display("FAIL force_range: up=%0b with force_port=3, required 0", bus_nr.link_up);
        end
        at_cyc(k + 4);
        r = cyc;
        bus_nr.force_en = 1'b0;
        push(2'd0, 1'b1, r + 1, r + 1);
        at_cyc(r + 1);
        checks++;
        if (bus_nr.active_port !== 2'd0 || bus_nr.link_up !== 1'b1) begin
            errors++;
            $display("FAIL force_release: port=%0d up=%0b, required port=0 up=1",
                     bus_nr.active_port, bus_nr.link_up);
        end
        bus_nr.force_port = '0;
        wait_drain("force");
    endtask

    task automatic test_saturation();
        int c;
        do_reset();
        sb_en = 1'b0;
        c = cyc;
        bus_nr.port_up = 3'b011;
        at_cyc(c + 10);
        bus_nr.force_port = 2'd0;
        bus_nr.force_en   = 1'b1;
        for (int i = 1; i <= 65540; i++) begin
            @(posedge clk);
            #1;
            if (i == 65534) begin
                checks++;
                if (bus_nr.switch_count !== 16'd65534) begin
                    errors++;
                    $display("FAIL sat_before: cnt=%0d, required 65534", bus_nr.switch_count);
                end
            end
            bus_nr.force_port = PW'(i & 1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_nr.switch_count !== 16'hFFFF || bus_nr.link_change !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: cnt=%h chg=%0b, required FFFF 1",
                     bus_nr.switch_count, bus_nr.link_change);
        end
        bus_nr.force_en = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        int c, r;
        do_reset();
        c = cyc;
        bus_nr.port_up = 3'b010;
        push(2'd1, 1'b1, c + 5, c + 5);
        at_cyc(c + 7);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_nr.active_port !== 2'd0 || bus_nr.link_up !== 1'b0 || bus_nr.speed !== 2'b00 ||
            bus_nr.full_duplex !== 1'b0 || bus_nr.link_change !== 1'b0 || bus_nr.switch_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_hold: port=%0d up=%0b speed=%0b dup=%0b chg=%0b cnt=%0d, required all zero",
                     bus_nr.active_port, bus_nr.link_up, bus_nr.speed, bus_nr.full_duplex,
                     bus_nr.link_change, bus_nr.switch_count);
        end
        wait_drain("pre_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        r = cyc;
        push(2'd1, 1'b1, r + 5, r + 5);
        at_cyc(r + 5);
        checks++;
        if (bus_nr.active_port !== 2'd1 || bus_nr.link_up !== 1'b1 || bus_nr.switch_count !== 16'd1) begin
            errors++;
            $display("FAIL reset_resume: port=%0d up=%0b cnt=%0d, required port=1 up=1 cnt=1",
                     bus_nr.active_port, bus_nr.link_up, bus_nr.switch_count);
        end
        wait_drain("resume");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_port();
        test_failover();
        test_simultaneous();
        test_revert();
        test_force();
        test_saturation();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
